// File: rtl/raisin64_wb_pkg.sv
// rtl/raisin64_wb_pkg.sv - shared types and helpers for the writeback arbiter
//
// Purpose: slot count, default register-number/data widths, the r0 constant,
//          a writeback slot record type and a wrapping index increment.
// Ports:   none (package).
// Config:  none here; the arbiter top honours WB_ARB_STARVE_EN.
package raisin64_wb_pkg;

  localparam int WB_SLOTS   = 2;
  localparam int DEF_RN_W   = 7;
  localparam int DEF_DATA_W = 64;

  localparam logic [DEF_RN_W-1:0] RN_ZERO = '0;

  typedef struct packed {
    logic                  en;
    logic [DEF_RN_W-1:0]   rn;
    logic [DEF_DATA_W-1:0] data;
  } wb_slot_t;

  // (idx + 1) mod n, for round-robin pointer updates
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rtl/wb_arbiter_rr_pick.sv - round-robin find-first-set from a pointer
//
// Purpose: picks the first unit with req & mask set, scanning upward from ptr
//          and wrapping modulo N. Purely combinational.
// Ports:
//   req    in  N       requesting units
//   mask   in  N       units allowed to win this pick
//   ptr    in  PTR_W   scan start index
//   grant  out N       one-hot winner (all zero when nothing found)
//   idx    out PTR_W   winner index (0 when nothing found)
//   found  out 1       a winner exists
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  logic [N-1:0] cand;

  always_comb begin
    cand  = req & mask;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && cand[(int'(ptr) + k) % N]) begin
        found                      = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx                        = PTR_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-slot round-robin writeback arbiter
//
// Purpose: grants up to two completed execution-unit results per cycle and
//          registers them into two writeback slots feeding the regfile write
//          ports and the pending-table free ports. One cycle latency.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   req_valid   in  NUM_UNITS         unit has a result
//   req_rn      in  NUM_UNITS*RN_W    dest reg, unit i at [i*RN_W +: RN_W]
//   req_data    in  NUM_UNITS*DATA_W  result, unit i at [i*DATA_W +: DATA_W]
//   req_ready   out NUM_UNITS         unit accepted this cycle (combinational)
//   wb_stall    in  1                 block all grants this cycle
//   wb_en       out 2                 slot writes back / frees a register
//   wb_rn       out 2*RN_W            slot register number
//   wb_data     out 2*DATA_W          slot write data
// Config: define WB_ARB_STARVE_EN to add per-unit wait counters that force a
//         unit waiting STARVE_LIMIT cycles into slot 0.
module wb_arbiter
  import raisin64_wb_pkg::*;
#(
  parameter int NUM_UNITS    = 4,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RN_W         = DEF_RN_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_UNITS-1:0]        req_valid,
  input  logic [NUM_UNITS*RN_W-1:0]   req_rn,
  input  logic [NUM_UNITS*DATA_W-1:0] req_data,
  output logic [NUM_UNITS-1:0]        req_ready,
  input  logic                        wb_stall,
  output logic [WB_SLOTS-1:0]         wb_en,
  output logic [WB_SLOTS*RN_W-1:0]    wb_rn,
  output logic [WB_SLOTS*DATA_W-1:0]  wb_data
);

  localparam int PTR_W = $clog2(NUM_UNITS);

  if (NUM_UNITS < 2 || NUM_UNITS > 8) begin : g_bad_units
    $error("wb_arbiter: NUM_UNITS must be 2..8");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("wb_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_UNITS-1:0] elig, mask1;
  logic [NUM_UNITS-1:0] rr_grant0, grant0, grant1;
  logic [PTR_W-1:0]     rr_idx0, idx0, idx1, last_idx;
  logic                 rr_found0, found0, found1;
  logic [RN_W-1:0]      rn0, rn1;
  logic [DATA_W-1:0]    data0, data1;

  // Nothing may be accepted while in reset or stalled.
  assign elig = req_valid & {NUM_UNITS{~wb_stall & rst_n}};

  rr_pick #(.N(NUM_UNITS), .PTR_W(PTR_W)) u_pick0 (
    .req   (elig),
    .mask  ({NUM_UNITS{1'b1}}),
    .ptr   (rr_ptr),
    .grant (rr_grant0),
    .idx   (rr_idx0),
    .found (rr_found0)
  );

`ifdef WB_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]     wait_cnt [NUM_UNITS];
  logic [NUM_UNITS-1:0] starved;
  logic                 starve_found;
  logic [PTR_W-1:0]     starve_idx;

  always_comb begin
    starved      = '0;
    starve_found = 1'b0;
    starve_idx   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      starved[i] = elig[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
    // Downward scan so the lowest starved index is the one left standing.
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (starved[i]) begin
        starve_found = 1'b1;
        starve_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    grant0 = rr_grant0;
    idx0   = rr_idx0;
    found0 = rr_found0;
    if (starve_found) begin
      grant0             = '0;
      grant0[starve_idx] = 1'b1;
      idx0               = starve_idx;
      found0             = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (!req_valid[i] || req_ready[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign grant0 = rr_grant0;
  assign idx0   = rr_idx0;
  assign found0 = rr_found0;
`endif

  assign rn0   = req_rn[idx0*RN_W +: RN_W];
  assign data0 = req_data[idx0*DATA_W +: DATA_W];

  // Slot 1 may not take slot 0's unit, nor a second write to slot 0's
  // register; r0 never conflicts since it is never written.
  always_comb begin
    mask1 = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      mask1[i] = ~grant0[i] &
                 ~((rn0 != '0) && (req_rn[i*RN_W +: RN_W] == rn0));
    end
  end

  rr_pick #(.N(NUM_UNITS), .PTR_W(PTR_W)) u_pick1 (
    .req   (elig),
    .mask  (mask1),
    .ptr   (rr_ptr),
    .grant (grant1),
    .idx   (idx1),
    .found (found1)
  );

  assign rn1       = req_rn[idx1*RN_W +: RN_W];
  assign data1     = req_data[idx1*DATA_W +: DATA_W];
  assign req_ready = grant0 | grant1;
  assign last_idx  = found1 ? idx1 : idx0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      wb_en   <= '0;
      wb_rn   <= '0;
      wb_data <= '0;
    end else begin
      if (found0) begin
        rr_ptr <= PTR_W'(wrap_inc(32'(last_idx), NUM_UNITS));
      end
      wb_en[0]                 <= found0 && (rn0 != '0);
      wb_en[1]                 <= found1 && (rn1 != '0);
      wb_rn[0 +: RN_W]         <= found0 ? rn0 : '0;
      wb_rn[RN_W +: RN_W]      <= found1 ? rn1 : '0;
      wb_data[0 +: DATA_W]     <= found0 ? data0 : '0;
      wb_data[DATA_W +: DATA_W] <= found1 ? data1 : '0;
    end
  end

endmodule
